// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IMMEX  = 4'd11,
        S_IMMWB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_IMM   = 2'd3;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
//
// state    | meaning
// S_RESET  | outputs quiet, hold RESET_PC_HOLD cycles after reset release
// S_FETCH  | read instruction at PC, PC+4; advance on MemReady
// S_DECODE | precompute branch target, dispatch on opcode
// S_MEMADR | ALUOut = A + sign-extended offset
// S_MEMRD  | load read at ALUOut, wait for MemReady
// S_MEMWB  | write MDR into rt
// S_MEMWR  | store write at ALUOut, wait for MemReady
// S_RTYPE  | A funct B
// S_ALUWB  | write ALUOut into rd
// S_BRANCH | compare A-B, conditional PC load from ALUOut
// S_JUMP   | PC load from jump target
// S_IMMEX  | A op extended immediate
// S_IMMWB  | write ALUOut into rt
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       ExtOp,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] hold_cnt;

    // addi sign-extends and adds; andi/ori zero-extend and use the logic op
    logic       imm_is_addi;
    assign imm_is_addi = (Opcode == OP_ADDI);

    assign State = cur_state;

    // State register; reset forces S_RESET regardless of pending memory waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_RESET;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Counts cycles spent in S_RESET after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 4'd0;
        end else if (cur_state == S_RESET && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 4'd1;
        end else begin
            hold_cnt <= 4'd0;
        end
    end

    // Next-state selection
    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            S_RESET:  if (hold_cnt == HOLD_LAST) nxt_state = S_FETCH;
            S_FETCH:  if (MemReady) nxt_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:             nxt_state = S_MEMADR;
                    OP_RTYPE:                 nxt_state = S_RTYPE;
                    OP_BEQ, OP_BNE:           nxt_state = S_BRANCH;
                    OP_J:                     nxt_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: nxt_state = S_IMMEX;
                    default:                  nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: nxt_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (MemReady) nxt_state = S_MEMWB;
            S_MEMWR:  if (MemReady) nxt_state = S_FETCH;
            S_MEMWB:  nxt_state = S_FETCH;
            S_RTYPE:  nxt_state = S_ALUWB;
            S_ALUWB:  nxt_state = S_FETCH;
            S_BRANCH: nxt_state = S_FETCH;
            S_JUMP:   nxt_state = S_FETCH;
            S_IMMEX:  nxt_state = S_IMMWB;
            S_IMMWB:  nxt_state = S_FETCH;
            default:  nxt_state = S_RESET;
        endcase
    end

    // Output decode; anything not set for a state stays 0
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_ADD;
        PCSrc       = PCSRC_ALU;
        ExtOp       = 1'b0;
        IllegalOp   = 1'b0;
        unique case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                ExtOp   = 1'b1;
                case (Opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J,
                    OP_ADDI, OP_ANDI, OP_ORI: IllegalOp = 1'b0;
                    default:                  IllegalOp = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_RTYPE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCSrc       = PCSRC_ALUOUT;
                PCWriteCond = ((Opcode == OP_BEQ) && Zero) ||
                              ((Opcode == OP_BNE) && !Zero);
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JUMP;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = imm_is_addi;
                ALUOp   = imm_is_addi ? ALU_ADD : ALU_IMM;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                ExtOp    = imm_is_addi;
                ALUOp    = imm_is_addi ? ALU_ADD : ALU_IMM;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS main control FSM.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = 6'h00;
    logic       MemReady = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] State;
    logic [17:0] all_outs;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control #(.RESET_PC_HOLD(3)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .ExtOp(ExtOp), .IllegalOp(IllegalOp), .State(State)
    );

    assign all_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, IllegalOp,
                       ALUSrcB, ALUOp, PCSrc};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and sample mid-cycle; memory/regwrite exclusivity every cycle
    task automatic cyc();
        @(negedge clk);
        #1;
        chk("rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        chk("rf_mem_excl", {31'd0, RegWrite & (MemRead | MemWrite)}, 32'd0);
    endtask

    initial begin
        // reset asserted
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", State, 32'd0);
        chk("rst_outs", all_outs, 32'd0);

        // release: three hold cycles, fetch on the fourth
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("hold1_state", State, 32'd0);
        chk("hold1_outs", all_outs, 32'd0);
        cyc();
        chk("hold2_state", State, 32'd0);
        chk("hold2_outs", all_outs, 32'd0);
        cyc();
        chk("hold3_state", State, 32'd0);
        chk("hold3_outs", all_outs, 32'd0);
        cyc();
        chk("fetch_state", State, 32'd1);

        // fetch stall: 4 cycles without MemReady
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            chk("stall_state", State, 32'd1);
            chk("stall_irwrite", IRWrite, 32'd0);
            chk("stall_pcwrite", PCWrite, 32'd0);
            chk("stall_memread", MemRead, 32'd1);
        end
        Opcode = OP_LW;
        MemReady = 1'b1;
        #1;
        chk("fetch_irwrite", IRWrite, 32'd1);
        chk("fetch_pcwrite", PCWrite, 32'd1);
        chk("fetch_srcb", ALUSrcB, 32'd1);

        // lw: 1,2,3,4,5,1
        cyc();
        chk("lw_decode", State, 32'd2);
        chk("dec_srcb", ALUSrcB, 32'd3);
        chk("dec_extop", ExtOp, 32'd1);
        cyc();
        chk("lw_memadr", State, 32'd3);
        chk("memadr_extop", ExtOp, 32'd1);
        chk("memadr_srcb", ALUSrcB, 32'd2);
        chk("memadr_srca", ALUSrcA, 32'd1);
        cyc();
        chk("lw_memrd", State, 32'd4);
        chk("memrd_iord", IorD, 32'd1);
        chk("memrd_read", MemRead, 32'd1);
        cyc();
        chk("lw_memwb", State, 32'd5);
        chk("memwb_regwrite", RegWrite, 32'd1);
        chk("memwb_memtoreg", MemtoReg, 32'd1);
        chk("memwb_regdst", RegDst, 32'd0);
        cyc();
        chk("lw_done", State, 32'd1);

        // beq with Zero=1 takes the branch
        Opcode = OP_BEQ;
        Zero = 1'b1;
        cyc();
        chk("beq_decode", State, 32'd2);
        cyc();
        chk("beq_branch", State, 32'd9);
        chk("beq_cond", PCWriteCond, 32'd1);
        chk("beq_aluop", ALUOp, 32'd1);
        chk("beq_pcsrc", PCSrc, 32'd1);
        cyc();
        chk("beq_done", State, 32'd1);

        // bne: not taken with Zero=1, taken once Zero drops
        Opcode = OP_BNE;
        cyc();
        cyc();
        chk("bne_branch", State, 32'd9);
        chk("bne_z1_cond", PCWriteCond, 32'd0);
        Zero = 1'b0;
        #1;
        chk("bne_z0_cond", PCWriteCond, 32'd1);
        cyc();
        chk("bne_done", State, 32'd1);

        // ori: zero-extend, logic op
        Opcode = OP_ORI;
        cyc();
        cyc();
        chk("ori_immex", State, 32'd11);
        chk("ori_extop", ExtOp, 32'd0);
        chk("ori_aluop", ALUOp, 32'd3);
        cyc();
        chk("ori_immwb", State, 32'd12);
        chk("ori_wb_regwrite", RegWrite, 32'd1);
        chk("ori_wb_extop", ExtOp, 32'd0);
        chk("ori_wb_aluop", ALUOp, 32'd3);
        cyc();
        chk("ori_done", State, 32'd1);

        // addi: sign-extend, add
        Opcode = OP_ADDI;
        cyc();
        cyc();
        chk("addi_immex", State, 32'd11);
        chk("addi_extop", ExtOp, 32'd1);
        chk("addi_aluop", ALUOp, 32'd0);
        cyc();
        chk("addi_immwb", State, 32'd12);
        chk("addi_wb_regdst", RegDst, 32'd0);
        cyc();
        chk("addi_done", State, 32'd1);

        // R-type
        Opcode = OP_RTYPE;
        cyc();
        cyc();
        chk("r_rtype", State, 32'd7);
        chk("r_aluop", ALUOp, 32'd2);
        chk("r_srcb", ALUSrcB, 32'd0);
        cyc();
        chk("r_aluwb", State, 32'd8);
        chk("r_regwrite", RegWrite, 32'd1);
        chk("r_regdst", RegDst, 32'd1);
        cyc();
        chk("r_done", State, 32'd1);

        // jump
        Opcode = OP_J;
        cyc();
        cyc();
        chk("j_jump", State, 32'd10);
        chk("j_pcwrite", PCWrite, 32'd1);
        chk("j_pcsrc", PCSrc, 32'd2);
        cyc();
        chk("j_done", State, 32'd1);

        // illegal opcode
        Opcode = 6'h3F;
        cyc();
        chk("ill_decode", State, 32'd2);
        chk("ill_pulse", IllegalOp, 32'd1);
        chk("ill_regwrite", RegWrite, 32'd0);
        chk("ill_memwrite", MemWrite, 32'd0);
        cyc();
        chk("ill_next", State, 32'd1);
        chk("ill_pulse_end", IllegalOp, 32'd0);

        // sw with memory wait, reset mid-wait
        Opcode = OP_SW;
        cyc();
        cyc();
        chk("sw_memadr", State, 32'd3);
        MemReady = 1'b0;
        cyc();
        chk("sw_memwr", State, 32'd6);
        chk("sw_memwrite", MemWrite, 32'd1);
        chk("sw_iord", IorD, 32'd1);
        cyc();
        chk("sw_wait", State, 32'd6);
        chk("sw_wait_memwrite", MemWrite, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("sw_rst_memwrite", MemWrite, 32'd0);
        chk("sw_rst_state", State, 32'd0);
        chk("sw_rst_outs", all_outs, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over shared resources: ALU, memory port, register file, PC, and the 16-to-32 immediate extender. The extender mode is driven through ExtOp, which selects sign or zero extension per instruction. The block sits beside the datapath top, reads only the opcode from the IR, and waits on a memory ready handshake.

Parameters:
RESET_PC_HOLD, 1, number of S_RESET cycles held after reset deassertion (1..15) before the first fetch.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
Opcode  in  6  IR[31:26]; valid from S_DECODE onward.
MemReady  in  1  memory access completes this cycle.
Zero  in  1  ALU zero flag (branch compare).
PCWrite  out  1  PC load, unconditional.
PCWriteCond  out  1  PC load if branch condition is true (already qualified internally).
IorD  out  1  memory address: 0=PC, 1=ALUOut.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
IRWrite  out  1  IR load.
MemtoReg  out  1  RF write data: 0=ALUOut, 1=MDR.
RegDst  out  1  RF dest: 0=rt, 1=rd.
RegWrite  out  1  RF write enable.
ALUSrcA  out  1  0=PC, 1=A.
ALUSrcB  out  2  0=B, 1=4, 2=ext imm, 3=ext imm<<2.
ALUOp  out  2  0=add, 1=sub, 2=funct, 3=imm-logic (uses Opcode).
PCSrc  out  2  0=ALU, 1=ALUOut, 2=jump target.
ExtOp  out  1  1=sign extend, 0=zero extend.
IllegalOp  out  1  one-cycle pulse on an unknown opcode.
State  out  4  current state encoding (debug).

Behaviour:
- Reset (async, rst_n=0): state=S_RESET; every output 0; hold counter cleared. After rst_n rises, stay RESET_PC_HOLD cycles in S_RESET with all outputs 0, then go to S_FETCH.
- States and encodings: S_RESET 0, S_FETCH 1, S_DECODE 2, S_MEMADR 3, S_MEMRD 4, S_MEMWB 5, S_MEMWR 6, S_RTYPE 7, S_ALUWB 8, S_BRANCH 9, S_JUMP 10, S_IMMEX 11, S_IMMWB 12.
- S_FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSrc=0. IRWrite and PCWrite are 1 only when MemReady=1, and the FSM then moves to S_DECODE. Otherwise it stays with both 0. Wait is unbounded.
- S_DECODE: ALUSrcA=0, ALUSrcB=3, ExtOp=1 (branch target precompute). Next state by Opcode:
  - 0x23/0x2B -> S_MEMADR
  - 0x00 -> S_RTYPE
  - 0x04/0x05 -> S_BRANCH
  - 0x02 -> S_JUMP
  - 0x08/0x0C/0x0D -> S_IMMEX
  - any other opcode -> S_FETCH, with IllegalOp=1 for that cycle.
- S_MEMADR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp=0. Next is S_MEMRD for 0x23, S_MEMWR for 0x2B (Opcode held stable by the IR).
- S_MEMRD: MemRead=1, IorD=1. On MemReady -> S_MEMWB, else stay.
- S_MEMWR: MemWrite=1, IorD=1. On MemReady -> S_FETCH, else stay. MemWrite stays high for the entire wait.
- S_MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> S_FETCH.
- S_RTYPE: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> S_ALUWB.
- S_ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> S_FETCH.
- S_BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSrc=1. PCWriteCond=1 iff (Opcode=0x04 and Zero) or (Opcode=0x05 and !Zero) -> S_FETCH.
- S_JUMP: PCWrite=1, PCSrc=2 -> S_FETCH.
- S_IMMEX: ALUSrcA=1, ALUSrcB=2. ExtOp=1 for 0x08, 0 for 0x0C/0x0D. ALUOp=0 for 0x08, 3 otherwise -> S_IMMWB.
- S_IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. ExtOp and ALUOp are held as in S_IMMEX -> S_FETCH.
- Outputs not listed for a state are 0.
- Cycle counts excluding memory waits: lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3.
- MemRead and MemWrite are never both 1. RegWrite and any memory request are never both 1.
- Reset asserted mid-instruction (including during a MemReady wait) forces S_RESET immediately and drops all outputs combinationally via the state register.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (4-bit, encodings above)
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI
  - ALUOp, ALUSrcB and PCSrc encodings.
- No sub-module. One state register process, one next-state block and one output decode block.

Test Plan:
- Reset/hold: rst_n low, then high with RESET_PC_HOLD=3 -> all outputs 0 for 3 cycles, State=1 on the 4th cycle.
- lw with MemReady=1 always -> State sequence 1,2,3,4,5,1. In S_MEMWB, RegWrite=1 and MemtoReg=1. ExtOp=1 in S_MEMADR.
- Fetch stall: MemReady low for 4 cycles in S_FETCH -> IRWrite=PCWrite=0 for 4 cycles, then both 1 for one cycle, then State=2.
- beq with Zero=1 -> PCWriteCond=1 in S_BRANCH. bne with Zero=1 -> PCWriteCond=0. ori -> ExtOp=0 and ALUOp=3 in S_IMMEX. addi -> ExtOp=1 and ALUOp=0.
- Illegal opcode 0x3F -> IllegalOp pulses 1 cycle in S_DECODE, next State=1, no RegWrite/MemWrite.
- sw with MemReady low 2 cycles, then rst_n dropped during the wait -> MemWrite falls to 0 immediately and State=0.
